seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, clock cycles each digit is displayed (minimum 2).
REQ-002 SHALL have parameter ANODE_ACTIVE_LOW, default 1: 1 = digit enable driven 0, 0 = driven 1.
REQ-003 SHALL have parameter SEG_ACTIVE_LOW, default 1: 1 = lit segment driven 0, 0 = driven 1.
REQ-004 SHALL have parameter BLANK_LZ, default 1: 1 = blank leading zeros, 0 = show all digits.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-007 SHALL have ports d1, d2, d3, d4, input, 4 each, BCD digits; d1 = ones, d2 = tens, d3 = hundreds, d4 = thousands.
REQ-008 SHALL have port an, output, 4, registered digit enables; an[k] drives the digit for d(k+1).
REQ-009 SHALL have port seg, output, 7, registered segment drive; seg[0]=a ... seg[6]=g.
REQ-010 SHALL have port dp, output, 1, decimal point, held at its inactive level.
REQ-011 SHALL have port frame_tick, output, 1, registered one-cycle pulse marking each snapshot capture.

Function
REQ-012 SHALL contain a prescaler that counts 0..REFRESH_DIV-1 and wraps to 0; its terminal count is the "step" condition.
REQ-013 SHALL contain a 2-bit digit index that advances 0->1->2->3->0 on each step, wrapping from 3 to 0.
REQ-014 SHALL load d1..d4 into a 16-bit snapshot register on a step with index==3, so a whole frame shows one consistent value.
REQ-015 SHALL leave the snapshot unchanged at all other times; input changes mid-frame SHALL NOT appear until the next capture.
REQ-016 SHALL pulse frame_tick high for exactly one cycle, in the cycle after the capture.
REQ-017 SHALL, in each cycle, register an and seg from the index and snapshot values of the previous cycle (one-cycle latency).
REQ-018 SHALL enable exactly one digit at a time: an[index] active, other three inactive, with polarity set by ANODE_ACTIVE_LOW.
REQ-019 SHALL decode as follows, listing lit segments:
- 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg
- 5=acdfg, 6=acdefg, 7=abc, 8=abcdefg, 9=abcdfg
REQ-020 SHALL decode codes 10..15 (invalid BCD) as segment g only (dash).
REQ-021 SHALL apply SEG_ACTIVE_LOW inversion after decoding.
REQ-022 SHALL, with BLANK_LZ=1, blank digit k (k=1..3) when snapshot digits k..3 are all zero: segments all unlit, anode still scanned.
REQ-023 SHALL never blank digit 0, so a value of 0 shows "0".
REQ-024 SHALL compare exactly 0 for blanking; an invalid code in a higher digit SHALL stop blanking below it.
REQ-025 SHALL hold dp inactive at all times: 1 if SEG_ACTIVE_LOW=1, else 0.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, set prescaler=0, index=0, snapshot=0, frame_tick=0.
REQ-027 SHALL, while rst=1 at a clock edge, drive all an inactive and all seg unlit.
REQ-028 SHALL give rst priority over every other update, including a reset asserted mid-frame; the frame SHALL restart from digit 0.
REQ-029 SHALL, on the first edge with rst=0, enable digit 0 showing "0".
REQ-030 SHALL perform the first capture at the end of the first full frame, 4*REFRESH_DIV cycles after reset release.

Verification (REFRESH_DIV=4, both polarity parameters =1, BLANK_LZ=1)
REQ-031 Reset then hold d=(0,1,0,0) -> frame 1 an=1110 with seg=1000000 ("0") while digits 1..3 show seg=1111111; frame 2 shows digit 1 "1" (seg=1111001) and digit 0 "0".
REQ-032 d2=0, d3=1 (value 100) -> digit 2 "1", digits 1 and 0 "0", digit 3 blank; each an pattern held exactly 4 cycles, sequence 1110, 1101, 1011, 0111.
REQ-033 Change d2 from 5 to 7 mid-frame -> remaining digits of that frame still show the old snapshot; frame_tick pulses once per 16 cycles; new value appears in the next frame.
REQ-034 d1=12 -> digit 0 seg=0111111 (dash); d4=11 with d3=d2=0 -> digits 3, 2, 1 show dash, "0", "0", none blanked.
REQ-035 Assert rst for 1 cycle during index 2 -> next edge an=1111, seg=1111111, frame_tick=0; following edge an=1110 showing "0".

Source files
------------

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver.
// Scans one digit every REFRESH_DIV cycles, shows a frame-consistent snapshot of the
// BCD inputs, and optionally blanks leading zeros. All outputs are registered.
module seg_scan_driver #(
    parameter int unsigned REFRESH_DIV      = 50000,
    parameter bit          ANODE_ACTIVE_LOW = 1'b1,
    parameter bit          SEG_ACTIVE_LOW   = 1'b1,
    parameter bit          BLANK_LZ         = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [3:0] d4,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [PW-1:0] r_presc;
    logic [1:0]    r_idx;
    logic [15:0]   r_snap;
    logic          r_tick;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;

    logic          w_step;
    logic [3:0]    w_digit;
    logic          w_blank;
    logic [6:0]    w_lit;
    logic [6:0]    w_shown;
    logic [3:0]    w_onehot;

    assign w_step   = (r_presc == PW'(REFRESH_DIV - 1));
    assign w_onehot = 4'(1) << r_idx;

    // Select the scanned digit and decide whether it is a leading zero.
    always_comb begin
        w_digit = 4'd0;
        w_blank = 1'b0;
        case (r_idx)
            2'd0: w_digit = r_snap[3:0];
            2'd1: begin
                w_digit = r_snap[7:4];
                w_blank = BLANK_LZ && (r_snap[15:4] == 12'd0);
            end
            2'd2: begin
                w_digit = r_snap[11:8];
                w_blank = BLANK_LZ && (r_snap[15:8] == 8'd0);
            end
            default: begin
                w_digit = r_snap[15:12];
                w_blank = BLANK_LZ && (r_snap[15:12] == 4'd0);
            end
        endcase
    end

    // BCD to lit-segment mask, bit 0 = a ... bit 6 = g; invalid codes give a dash.
    always_comb begin
        w_lit = 7'b1000000;
        case (w_digit)
            4'd0:    w_lit = 7'b0111111;
            4'd1:    w_lit = 7'b0000110;
            4'd2:    w_lit = 7'b1011011;
            4'd3:    w_lit = 7'b1001111;
            4'd4:    w_lit = 7'b1100110;
            4'd5:    w_lit = 7'b1101101;
            4'd6:    w_lit = 7'b1111101;
            4'd7:    w_lit = 7'b0000111;
            4'd8:    w_lit = 7'b1111111;
            4'd9:    w_lit = 7'b1101111;
            default: w_lit = 7'b1000000;
        endcase
        w_shown = w_blank ? 7'd0 : w_lit;
    end

    // Prescaler, digit index, frame snapshot and capture pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= 2'd0;
            r_snap  <= 16'd0;
            r_tick  <= 1'b0;
        end else begin
            r_presc <= w_step ? '0 : r_presc + PW'(1);
            r_tick  <= w_step && (r_idx == 2'd3);
            if (w_step) begin
                r_idx <= r_idx + 2'd1;
                if (r_idx == 2'd3) begin
                    r_snap <= {d4, d3, d2, d1};
                end
            end
        end
    end

    // Output registers, one cycle behind index/snapshot; polarity applied last.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an  <= {4{ANODE_ACTIVE_LOW}};
            r_seg <= {7{SEG_ACTIVE_LOW}};
        end else begin
            r_an  <= w_onehot ^ {4{ANODE_ACTIVE_LOW}};
            r_seg <= w_shown ^ {7{SEG_ACTIVE_LOW}};
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign frame_tick = r_tick;
    assign dp         = SEG_ACTIVE_LOW;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver with REFRESH_DIV=4, active-low outputs, leading-zero blanking.
// Expected outputs come from elapsed-cycle arithmetic and a segment-letter table.
module tb_seg_scan_driver;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] d1, d2, d3, d4;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    int errors = 0;
    int checks = 0;

    // Reference state: edges since the last reset edge and the value on display.
    int          n_edges;
    bit          started = 1'b0;
    logic [15:0] m_snap;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_tick;

    string lit_tab [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg",
                            "abc", "abcdefg", "abcdfg", "g", "g", "g", "g", "g", "g"};

    seg_scan_driver #(
        .REFRESH_DIV     (DIV),
        .ANODE_ACTIVE_LOW(1'b1),
        .SEG_ACTIVE_LOW  (1'b1),
        .BLANK_LZ        (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .d4        (d4),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Active-low segment pattern for digit position pos of a four-digit value.
    function automatic logic [6:0] seg_expect(input logic [15:0] val, input int pos);
        logic [6:0] mask;
        string      s;
        int         code;
        mask = 7'd0;
        code = int'((val >> (4 * pos)) & 16'hF);
        if (pos > 0 && (val >> (4 * pos)) == 16'd0) return 7'b1111111;
        s = lit_tab[code];
        for (int i = 0; i < s.len(); i++) mask[s[i] - "a"] = 1'b1;
        return ~mask;
    endfunction

    task automatic model_edge(input logic r, input logic [15:0] din);
        int pos;
        if (r) begin
            started = 1'b1;
            n_edges = 0;
            m_snap  = 16'd0;
            e_an    = 4'b1111;
            e_seg   = 7'b1111111;
            e_tick  = 1'b0;
        end else if (started) begin
            n_edges++;
            pos    = ((n_edges - 1) / DIV) % 4;
            e_an   = ~(4'b0001 << pos);
            e_seg  = seg_expect(m_snap, pos);
            e_tick = (n_edges % FRAME == 0);
            if (n_edges % FRAME == 0) m_snap = din;
        end
    endtask

    task automatic step(input logic r, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] e);
        rst = r;
        d1  = a;
        d2  = b;
        d3  = c;
        d4  = e;
        @(posedge clk);
        model_edge(r, {e, c, b, a});
        #1;
        if (started) begin
            check("an", 32'(an), 32'(e_an));
            check("seg", 32'(seg), 32'(e_seg));
            check("frame_tick", 32'(frame_tick), 32'(e_tick));
            check("dp", 32'(dp), 32'd1);
        end
    endtask

    initial begin
        rst = 1'b1;
        {d1, d2, d3, d4} = '0;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        // Value 10: first frame shows "0" only, second frame shows "10".
        step(0, 0, 1, 0, 0);
        check("first_digit_an", 32'(an), 32'(4'b1110));
        check("first_digit_seg", 32'(seg), 32'(7'b1000000));
        for (int i = 1; i < FRAME + DIV + 1; i++) step(0, 0, 1, 0, 0);
        check("frame2_d1_an", 32'(an), 32'(4'b1101));
        check("frame2_d1_seg", 32'(seg), 32'(7'b1111001));
        for (int i = 0; i < FRAME; i++) step(0, 0, 1, 0, 0);

        // Value 100 across two frames.
        for (int i = 0; i < 2 * FRAME; i++) step(0, 0, 0, 1, 0);

        // Tens digit changes 5 -> 7 in the middle of a frame.
        for (int i = 0; i < FRAME + 6; i++) step(0, 3, 5, 0, 0);
        for (int i = 0; i < 2 * FRAME; i++) step(0, 3, 7, 0, 0);

        // Invalid codes: dash in ones; dash in thousands stops blanking.
        for (int i = 0; i < 2 * FRAME; i++) step(0, 12, 0, 0, 0);
        for (int i = 0; i < 2 * FRAME; i++) step(0, 0, 0, 0, 11);

        // Reset pulse while digit 2 is being scanned.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 2 * DIV + 1; i++) step(0, 8, 8, 8, 8);
        step(1, 8, 8, 8, 8);
        check("rst_mid_an", 32'(an), 32'(4'b1111));
        check("rst_mid_seg", 32'(seg), 32'(7'b1111111));
        check("rst_mid_tick", 32'(frame_tick), 32'd0);
        step(0, 8, 8, 8, 8);
        check("after_rst_an", 32'(an), 32'(4'b1110));
        check("after_rst_seg", 32'(seg), 32'(7'b1000000));

        // Random inputs with occasional resets; zero-biased digits exercise blanking.
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] v [4];
            for (int k = 0; k < 4; k++) begin
                v[k] = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom_range(15));
            end
            if ($urandom_range(7) != 0) begin
                v[0] = d1;
                v[1] = d2;
                v[2] = d3;
                v[3] = d4;
            end
            step(($urandom_range(99) == 0), v[0], v[1], v[2], v[3]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
